// File: rtl/ej32_mem_arb.sv
// eJ32 single-port SPRAM arbiter: boot phase, fixed priority,
// locked load/store bursts and starvation aging for the I/O drain.
module ej32_mem_arb #(
  parameter int ASZ      = 17,
  parameter int STARVE   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           boot_act,
  input  logic           boot_req,
  input  logic [ASZ-1:0] boot_a,
  input  logic [7:0]     boot_d,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic           ls_lock,
  input  logic [ASZ-1:0] ls_a,
  input  logic [7:0]     ls_d,
  input  logic           if_req,
  input  logic [ASZ-1:0] if_a,
  input  logic           io_req,
  input  logic [ASZ-1:0] io_a,
  output logic [3:0]     gnt,
  output logic [3:0]     rvld,
  output logic [7:0]     rdata,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_d,
  input  logic [7:0]     mem_q,
  output logic           lock_err
);

  localparam int WW = $clog2(STARVE + 1);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    LOCK
  } state_t;

  state_t         r_state;
  logic [WW-1:0]  r_io_wait;
  logic [CW-1:0]  r_lock_cnt;
  logic           r_lock_err;
  logic [3:0]     r_rvld;
  logic [ASZ-1:0] r_last_a;
  logic [7:0]     r_last_d;

  logic [3:0]     w_gnt;
  logic           w_starve;
  logic           w_we;
  logic [ASZ-1:0] w_a;
  logic [7:0]     w_d;
  logic [CW-1:0]  w_cnt_nxt;

  assign w_starve  = (r_io_wait == WW'(STARVE));
  assign w_cnt_nxt = r_lock_cnt + CW'(w_gnt[1]);

  always_comb begin
    w_gnt = '0;
    case (r_state)
      BOOT: w_gnt[0] = boot_req & boot_act;
      RUN: begin
        if (ls_req)                 w_gnt[1] = 1'b1;
        else if (io_req & w_starve) w_gnt[3] = 1'b1;
        else if (if_req)            w_gnt[2] = 1'b1;
        else if (io_req)            w_gnt[3] = 1'b1;
      end
      LOCK: w_gnt[1] = ls_req;
      default: w_gnt = '0;
    endcase
  end

  // Idle bus replays the last command so the RAM pins do not toggle
  always_comb begin
    w_a  = r_last_a;
    w_d  = r_last_d;
    w_we = 1'b0;
    unique case (1'b1)
      w_gnt[0]: begin
        w_a  = boot_a;
        w_d  = boot_d;
        w_we = 1'b1;
      end
      w_gnt[1]: begin
        w_a  = ls_a;
        w_d  = ls_d;
        w_we = ls_we;
      end
      w_gnt[2]: w_a = if_a;
      w_gnt[3]: w_a = io_a;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_io_wait  <= '0;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
      r_rvld     <= '0;
      r_last_a   <= '0;
      r_last_d   <= '0;
    end else begin
      r_rvld   <= {w_gnt[3:1] & {3{~w_we}}, 1'b0};
      r_last_a <= w_a;
      r_last_d <= w_d;
      if (r_state == BOOT || !io_req || w_gnt[3])
        r_io_wait <= '0;
      else if (!w_starve)
        r_io_wait <= r_io_wait + 1'b1;
      case (r_state)
        BOOT: if (!boot_act) r_state <= RUN;
        RUN: begin
          if (w_gnt[1] && ls_lock) begin
            r_state    <= LOCK;
            r_lock_cnt <= CW'(1);
          end
        end
        LOCK: begin
          if (!ls_lock) begin
            r_state    <= RUN;
            r_lock_cnt <= '0;
          end else if (w_cnt_nxt == CW'(LOCK_MAX)) begin
            r_state    <= RUN;
            r_lock_cnt <= '0;
            r_lock_err <= 1'b1;
          end else begin
            r_lock_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign gnt      = w_gnt;
  assign rvld     = r_rvld;
  assign rdata    = mem_q;
  assign mem_a    = w_a;
  assign mem_d    = w_d;
  assign mem_we   = w_we;
  assign lock_err = r_lock_err;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Testbench for ej32_mem_arb: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.
module tb_ej32_mem_arb;
  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst;
  logic           boot_act, boot_req;
  logic [ASZ-1:0] boot_a;
  logic [7:0]     boot_d;
  logic           ls_req, ls_we, ls_lock;
  logic [ASZ-1:0] ls_a;
  logic [7:0]     ls_d;
  logic           if_req;
  logic [ASZ-1:0] if_a;
  logic           io_req;
  logic [ASZ-1:0] io_a;
  logic [3:0]     gnt, rvld;
  logic [7:0]     rdata;
  logic [ASZ-1:0] mem_a;
  logic           mem_we;
  logic [7:0]     mem_d, mem_q;
  logic           lock_err;

  int n_tests = 0;
  int n_fail  = 0;

  ej32_mem_arb #(.ASZ(ASZ), .STARVE(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .boot_act(boot_act), .boot_req(boot_req),
    .boot_a(boot_a), .boot_d(boot_d),
    .ls_req(ls_req), .ls_we(ls_we), .ls_lock(ls_lock),
    .ls_a(ls_a), .ls_d(ls_d),
    .if_req(if_req), .if_a(if_a),
    .io_req(io_req), .io_a(io_a),
    .gnt(gnt), .rvld(rvld), .rdata(rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d),
    .mem_q(mem_q), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Reference model: booting/locked flags, wait and burst counters
  bit             mb_boot, mb_lock, m_err;
  int             m_wait, m_cnt;
  logic [3:0]     m_rv;
  logic [ASZ-1:0] m_la;
  logic [7:0]     m_ld;
  logic [3:0]     e_gnt;
  logic           e_we;
  logic [ASZ-1:0] e_a;
  logic [7:0]     e_d;

  function automatic void model_reset();
    mb_boot = 1; mb_lock = 0; m_err = 0;
    m_wait = 0; m_cnt = 0; m_rv = 0;
    m_la = '0; m_ld = '0;
  endfunction

  function automatic void model_eval();
    e_gnt = 4'b0000;
    if (mb_boot) begin
      if (boot_act && boot_req) e_gnt = 4'b0001;
    end else if (mb_lock) begin
      if (ls_req) e_gnt = 4'b0010;
    end else if (ls_req) e_gnt = 4'b0010;
    else if (io_req && m_wait >= 8) e_gnt = 4'b1000;
    else if (if_req) e_gnt = 4'b0100;
    else if (io_req) e_gnt = 4'b1000;
    e_a = m_la; e_d = m_ld; e_we = 1'b0;
    if (e_gnt == 4'b0001) begin e_a = boot_a; e_d = boot_d; e_we = 1'b1; end
    if (e_gnt == 4'b0010) begin e_a = ls_a; e_d = ls_d; e_we = ls_we; end
    if (e_gnt == 4'b0100) e_a = if_a;
    if (e_gnt == 4'b1000) e_a = io_a;
  endfunction

  function automatic void model_tick();
    m_rv = e_we ? 4'b0000 : (e_gnt & 4'b1110);
    m_la = e_a; m_ld = e_d;
    if (mb_boot) begin
      m_wait = 0;
      if (!boot_act) mb_boot = 0;
    end else begin
      if (!io_req || e_gnt[3]) m_wait = 0;
      else if (m_wait < 8) m_wait = m_wait + 1;
      if (!mb_lock) begin
        if (e_gnt[1] && ls_lock) begin mb_lock = 1; m_cnt = 1; end
      end else begin
        if (e_gnt[1]) m_cnt = m_cnt + 1;
        if (!ls_lock) mb_lock = 0;
        else if (m_cnt == 4) begin mb_lock = 0; m_err = 1; end
      end
    end
  endfunction

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic adv();
    model_tick();
    @(posedge clk);
    #1;
    mem_q = 8'($urandom);
  endtask

  task automatic idle_inputs();
    boot_req = 0; ls_req = 0; ls_we = 0; ls_lock = 0;
    if_req = 0; io_req = 0;
  endtask

  task automatic test_reset();
    boot_act = 1; boot_req = 0; ls_req = 1; if_req = 1; io_req = 1;
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: gnt=%b we=%b, expected 0000 0", gnt, mem_we);
    end
    n_tests++;
    if (rvld !== 4'b0000 || lock_err !== 1'b0 || mem_a !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: rvld=%b err=%b a=%h, expected 0 0 0",
               rvld, lock_err, mem_a);
    end
    boot_req = 1; boot_a = 17'h55; boot_d = 8'h3C;
    #1;
    n_tests++;
    if (gnt !== 4'b0001 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_bootreq: gnt=%b we=%b, expected 0001 1", gnt, mem_we);
    end
  endtask

  task automatic test_boot();
    idle_inputs();
    boot_act = 1; boot_req = 1; boot_a = 17'h10; boot_d = 8'hA5;
    ls_req = 1; ls_a = 17'h200; if_req = 1; if_a = 17'h40;
    settle();
    n_tests++;
    if (gnt !== 4'b0001 || mem_we !== 1'b1 || mem_a !== 17'h10 || mem_d !== 8'hA5) begin
      n_fail++;
      $display("FAIL boot_excl: gnt=%b we=%b a=%h d=%h, expected 0001 1 10 a5",
               gnt, mem_we, mem_a, mem_d);
    end
    adv();
    boot_act = 0; boot_req = 0;
    settle();
    n_tests++;
    if (gnt !== 4'b0000 || mem_we !== 1'b0 || mem_a !== 17'h10) begin
      n_fail++;
      $display("FAIL boot_exit: gnt=%b we=%b a=%h, expected 0000 0 10",
               gnt, mem_we, mem_a);
    end
    adv();
    settle();
    n_tests++;
    if (gnt !== 4'b0010 || gnt !== e_gnt) begin
      n_fail++;
      $display("FAIL boot_to_run: gnt=%b, expected 0010", gnt);
    end
    adv();
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_priority();
    ls_req = 1; ls_we = 0; ls_a = 17'h200; if_req = 1; if_a = 17'h44;
    settle();
    n_tests++;
    if (gnt !== 4'b0010 || mem_a !== 17'h200 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ls: gnt=%b a=%h we=%b, expected 0010 200 0",
               gnt, mem_a, mem_we);
    end
    adv();
    ls_req = 0;
    settle();
    n_tests++;
    if (rvld !== 4'b0010 || rdata !== mem_q) begin
      n_fail++;
      $display("FAIL prio_rvld: rvld=%b rdata=%h, expected 0010 %h", rvld, rdata, mem_q);
    end
    n_tests++;
    if (gnt !== 4'b0100 || mem_a !== 17'h44) begin
      n_fail++;
      $display("FAIL prio_if: gnt=%b a=%h, expected 0100 44", gnt, mem_a);
    end
    adv();
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_burst();
    if_req = 1; io_req = 1; ls_req = 1; ls_we = 0;
    for (int i = 0; i < 4; i++) begin
      ls_lock = (i < 3);
      ls_a = ASZ'(17'h300 + i);
      settle();
      n_tests++;
      if (gnt !== 4'b0010 || mem_a !== ls_a || gnt !== e_gnt) begin
        n_fail++;
        $display("FAIL burst_%0d: gnt=%b a=%h, expected 0010 %h", i, gnt, mem_a, ls_a);
      end
      if (i > 0) begin
        n_tests++;
        if (rvld !== 4'b0010) begin
          n_fail++;
          $display("FAIL burst_rvld_%0d: rvld=%b, expected 0010", i, rvld);
        end
      end
      adv();
    end
    ls_req = 0; ls_lock = 0;
    settle();
    n_tests++;
    if (gnt !== 4'b0100 || lock_err !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end: gnt=%b err=%b, expected 0100 0", gnt, lock_err);
    end
    adv();
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_lock_timeout();
    int granted;
    int guard;
    granted = 0; guard = 0;
    if_req = 1; ls_lock = 1; ls_we = 0;
    while (granted < 6 && guard < 20) begin
      ls_req = 1;
      ls_a = ASZ'(17'h400 + granted);
      settle();
      n_tests++;
      if (gnt !== e_gnt || gnt !== 4'b0010) begin
        n_fail++;
        $display("FAIL lock_to_gnt_%0d: gnt=%b, expected %b", granted, gnt, e_gnt);
      end
      if (gnt[1]) granted++;
      adv();
      guard++;
      if (granted == 4) begin
        n_tests++;
        if (lock_err !== 1'b1) begin
          n_fail++;
          $display("FAIL lock_err_set: lock_err=%b, expected 1", lock_err);
        end
      end
    end
    n_tests++;
    if (granted != 6) begin
      n_fail++;
      $display("FAIL lock_to_count: granted=%0d, expected 6", granted);
    end
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_starve();
    logic [3:0] want;
    if_req = 1; io_req = 1; if_a = 17'h60; io_a = 17'h70;
    for (int k = 0; k < 20; k++) begin
      want = (k % 9 == 8) ? 4'b1000 : 4'b0100;
      settle();
      n_tests++;
      if (gnt !== want) begin
        n_fail++;
        $display("FAIL starve_%0d: gnt=%b, expected %b", k, gnt, want);
      end
      adv();
    end
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      ls_req  = ($urandom_range(0, 3) == 0);
      ls_we   = $urandom_range(0, 1) == 1;
      ls_lock = ($urandom_range(0, 4) == 0);
      if_req  = $urandom_range(0, 1) == 1;
      io_req  = ($urandom_range(0, 3) != 0);
      boot_req = $urandom_range(0, 1) == 1;
      ls_a = ASZ'($urandom); ls_d = 8'($urandom);
      if_a = ASZ'($urandom); io_a = ASZ'($urandom);
      boot_a = ASZ'($urandom); boot_d = 8'($urandom);
      settle();
      n_tests++;
      if (gnt !== e_gnt || mem_we !== e_we || mem_a !== e_a || mem_d !== e_d) begin
        n_fail++;
        $display("FAIL rand_cmd_%0d: gnt=%b we=%b a=%h d=%h, expected %b %b %h %h",
                 k, gnt, mem_we, mem_a, mem_d, e_gnt, e_we, e_a, e_d);
      end
      n_tests++;
      if (rvld !== m_rv || (|rvld && rdata !== mem_q) || lock_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_rd_%0d: rvld=%b err=%b, expected %b %b",
                 k, rvld, lock_err, m_rv, m_err);
      end
      adv();
    end
    idle_inputs();
    settle();
    adv();
  endtask

  task automatic test_async_reset();
    ls_req = 1; ls_we = 0; ls_lock = 1; ls_a = 17'h500; if_req = 1;
    settle();
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL arst_gnt: gnt=%b, expected 0010", gnt);
    end
    adv();
    n_tests++;
    if (rvld !== 4'b0010) begin
      n_fail++;
      $display("FAIL arst_pre: rvld=%b, expected 0010", rvld);
    end
    #1 rst = 1;
    #1;
    model_reset();
    n_tests++;
    if (rvld !== 4'b0000 || gnt !== 4'b0000 || lock_err !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_clear: rvld=%b gnt=%b err=%b, expected 0000 0000 0",
               rvld, gnt, lock_err);
    end
    boot_act = 1; boot_req = 1; boot_a = 17'h1;
    #1;
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL arst_boot: gnt=%b, expected 0001", gnt);
    end
  endtask

  initial begin
    rst = 1; boot_act = 1;
    boot_a = '0; boot_d = '0; ls_a = '0; ls_d = '0;
    if_a = '0; io_a = '0; mem_q = '0;
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    test_boot();
    test_priority();
    test_burst();
    test_lock_timeout();
    test_starve();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ej32_mem_arb.md
# ej32_mem_arb

Single-port arbiter for the 8-bit SPRAM bus of the eJ32 core. It shares the one memory port among four requesters: the ROM boot loader, the load/store unit, instruction fetch, and an I/O drain engine that empties the output buffer. It sits between the core units and the `mb8_io` slave port. It provides fixed priority, an exclusive boot phase, locked multi-byte bursts for the load/store unit, and starvation aging for the I/O requester.

## Interface
Parameters:
- `ASZ`, 17, address width in bits.
- `STARVE`, 8, number of consecutive denied cycles after which `io` outranks `if`.
- `LOCK_MAX`, 4, maximum number of consecutive locked load/store grants.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `boot_act`  in  1  level; high while the ROM image copy is in progress.
- `boot_req`, `boot_a[ASZ]`, `boot_d[8]`  in  boot write request, address, data. Boot is write-only.
- `ls_req`, `ls_we`, `ls_lock`  in  1 each  load/store request, write enable, burst lock.
- `ls_a[ASZ]`, `ls_d[8]`  in  load/store address and write data.
- `if_req`, `if_a[ASZ]`  in  instruction fetch request and address. Read-only.
- `io_req`, `io_a[ASZ]`  in  I/O drain request and address. Read-only.
- `gnt[4]`  out  combinational one-hot grant: [0]=boot, [1]=ls, [2]=if, [3]=io.
- `rvld[4]`  out  registered read-data-valid, same bit order as `gnt`.
- `rdata[8]`  out  equals `mem_q`; meaningful only while any `rvld` bit is high.
- `mem_a[ASZ]`, `mem_we`, `mem_d[8]`  out  memory command, muxed from the granted requester.
- `mem_q[8]`  in  memory read data. The RAM is clocked on the negedge, so `mem_q` is valid in the cycle after the command.
- `lock_err`  out  1  sticky; set when a lock is force-released.

## Operation
- States: BOOT, RUN, LOCK. Reset enters BOOT.
- **BOOT**
  - `gnt[0]=boot_req`; all other grants are 0.
  - `mem_we=boot_req`; `mem_a=boot_a`; `mem_d=boot_d`.
  - When `boot_act` is low, go to RUN on the next posedge. Nothing is granted in that exit cycle.
- **RUN**: priority is `ls` > `if` > `io`.
  - Exception: when `io_wait==STARVE`, `io` outranks `if` (never `ls`).
  - `boot_req` is ignored in RUN.
- **LOCK entry**: an `ls` grant in RUN with `ls_lock=1` moves to LOCK. Set `lock_cnt=1`.
- **LOCK**
  - Only `ls` may be granted. `gnt[1]=ls_req`.
  - Each `ls` grant increments `lock_cnt`.
  - If `ls_lock=0` in a LOCK cycle, grant that access if `ls_req` is high, then return to RUN.
  - If `lock_cnt==LOCK_MAX` and `ls_lock` is still 1, force a return to RUN and set `lock_err`. `lock_err` clears only on `rst`.
  - The lock is not released while `ls_req` is low with `ls_lock` high; LOCK holds through gaps.
- **Starvation counter `io_wait`**
  - Increments, saturating at `STARVE`, each cycle with `io_req & ~gnt[3]`.
  - Clears on `gnt[3]` or when `io_req=0`.
  - Counts only in RUN and LOCK.
- **Write enable**: `mem_we` = `ls_we` when `ls` is granted, 1 when `boot` is granted, otherwise 0.
- **Idle bus**: with no grant, `mem_we=0`, and `mem_a`/`mem_d` hold the last granted values (no toggling).
- **Read valid**: `rvld[i]` is registered `gnt[i] & ~mem_we`. `rvld[0]` is always 0.

## Timing
- Grant is combinational: it is issued in the same cycle as the request, and the command is captured by the RAM on that cycle's negedge.
- Read latency is 1 cycle: grant in cycle N gives `rvld` and `rdata` in cycle N+1.
- Back-to-back grants to the same or different requesters are allowed every cycle. Throughput is 1 byte/cycle.
- A requester holds `req` and its address/data stable until it samples its `gnt` high at a posedge. Dropping `req` without a grant is legal.
- A 4-byte `ls` burst with the lock held completes in 4 consecutive cycles. Data returns in cycles 2–5.
- Reset values:
  - state=BOOT, `io_wait=0`, `lock_cnt=0`, `lock_err=0`, `rvld=0`.
  - `gnt=0` and `mem_we=0` unless `boot_req` is high.
  - Last-address register = 0.
- Reset mid-operation: `rst` asserted in any state, including mid-burst, immediately clears `rvld` and `gnt[1..3]` and returns to BOOT. Any in-flight read is discarded.

## Test plan
- **Boot exclusivity**: `boot_act=1`, `boot_req=1`, `boot_a=0x10`, `boot_d=0xA5`, with `ls_req=if_req=1` → `gnt=0001`, `mem_we=1`, `mem_a=0x10`, `mem_d=0xA5`. After `boot_act` falls, one idle cycle, then `gnt=0010`.
- **Priority and read latency**: in RUN, `ls_req` (read, `0x200`) and `if_req` in the same cycle → `gnt=0010`, and `rvld=0010` next cycle with `rdata=mem_q`. With `ls_req` dropped, `if` is granted the following cycle.
- **Locked burst**: `ls_lock=1` for 4 reads at `0x300..0x303`, with `if_req`/`io_req` held high → four consecutive `gnt=0010`, then `if` granted in cycle 5. `lock_err=0`.
- **Lock timeout**: `ls_lock` held high for 6 `ls` requests with `LOCK_MAX=4` → 4 locked grants, `lock_err=1`, return to RUN, and `ls` is re-granted by priority.
- **Starvation**: `if_req` and `io_req` held high continuously → `if` granted for 8 cycles, then `gnt=1000` once, then `if` resumes. `io_wait` reads 0 after the `io` grant.
- **Async reset mid-burst**: `rst` asserted between a locked `ls` grant and its `rvld` → `rvld=0` and state=BOOT with no clock edge. `lock_err` cleared.
